rv32_ifetch: RTL and testbench

Instruction fetch stage for the priRV32 core. It sits between the instruction memory port and the decode stage. It owns the fetch PC and issues sequential word requests over a valid/ready request channel. It buffers in-order responses in a small prefetch FIFO and presents {pc, instr} to decode over a valid/ready handshake. A redirect (branch/jump/trap) flushes all buffered and in-flight work and restarts fetch at a new PC.

---
 rtl/rv32_ifetch.sv | 150 +++++++++++++++
 tb/tb_rv32_ifetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_ifetch.sv
// ---------------------------------------------------------------------------
// rv32_ifetch
//
// Instruction fetch stage for the priRV32 core.
//
// The stage owns the fetch PC and issues sequential word requests to the
// instruction memory. In-order responses are buffered in a small prefetch
// FIFO, and each entry is presented to decode as {pc, instr}. A redirect
// (branch, jump or trap) flushes everything buffered. Responses that are
// still in flight when the redirect happens are counted and thrown away as
// they arrive. Fetch then restarts at the new PC.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//   DEPTH           prefetch FIFO entries, which is also the number of
//                   in-flight credits (power of two, >= 2)
//
// Ports:
//   clk             core clock, rising edge
//   reset           synchronous, active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   word-aligned fetch address
//   imem_rsp_valid  response valid (in request order, no backpressure)
//   imem_rsp_data   instruction word
//   redirect_valid  flush and restart fetch
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   if_valid        decode entry valid
//   if_ready        decode accepts the entry
//   if_pc           PC of the presented instruction
//   if_instr        presented instruction
// ---------------------------------------------------------------------------
module rv32_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetchPc;
   logic [31:0]   r_rspPc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_dropCnt;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_rdPtr;
   logic [AW-1:0] r_wrPtr;
   logic [31:0]   r_pcMem    [DEPTH];
   logic [31:0]   r_instrMem [DEPTH];

   logic [CW:0]   w_credit;
   logic          w_pop;
   logic          w_acc;
   logic          w_rsp;
   logic          w_drop;
   logic          w_push;
   logic [31:0]   w_redirPc;
   logic [1:0]    w_unusedPcBits;

   // Handshake decode. A slot counts against the credit budget from the
   // cycle its request is accepted until decode pops the entry. This means
   // a request issued against a free credit always has FIFO space when its
   // response lands. A pop in the same cycle frees a credit early. That is
   // the only combinational path from if_ready to imem_req_valid.
   assign w_credit       = {1'b0, r_outstanding} + {1'b0, r_count};
   assign if_valid       = ~reset & ~redirect_valid & (r_count != '0);
   assign w_pop          = if_valid & if_ready;
   assign imem_req_valid = ~reset & ~redirect_valid &
                           ((w_credit < CREDIT_MAX) |
                            ((w_credit == CREDIT_MAX) & w_pop));
   assign imem_req_addr  = reset ? RESET_PC : r_fetchPc;
   assign w_acc          = imem_req_valid & imem_req_ready;
   assign w_rsp          = imem_rsp_valid;
   assign w_drop         = w_rsp & (r_dropCnt != '0);
   assign w_push         = w_rsp & ~w_drop & ~redirect_valid;
   assign w_redirPc      = {redirect_pc[31:2], 2'b00};
   assign w_unusedPcBits = redirect_pc[1:0];

   // The decode view is taken straight from the FIFO head. A response is
   // never forwarded in the cycle it arrives.
   assign if_pc    = r_pcMem[r_rdPtr];
   assign if_instr = r_instrMem[r_rdPtr];

   // Control state. Reset takes priority over redirect. A redirect empties
   // the FIFO and restarts both PCs. Every request still in flight at that
   // point becomes a stale response that must be dropped. A response
   // arriving in the redirect cycle is already discarded here, so it is
   // subtracted from the drop count. The outstanding counter keeps tracking
   // the memory side across the redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetchPc     <= RESET_PC;
         r_rspPc       <= RESET_PC;
         r_outstanding <= '0;
         r_dropCnt     <= '0;
         r_count       <= '0;
         r_rdPtr       <= '0;
         r_wrPtr       <= '0;
      end else if (redirect_valid) begin
         r_fetchPc     <= w_redirPc;
         r_rspPc       <= w_redirPc;
         r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_rsp);
         r_dropCnt     <= r_outstanding - CW'(w_rsp);
         r_count       <= '0;
         r_rdPtr       <= '0;
         r_wrPtr       <= '0;
      end else begin
         if (w_acc) begin
            r_fetchPc <= r_fetchPc + 32'd4;
         end
         r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_rsp);
         if (w_drop) begin
            r_dropCnt <= r_dropCnt - CW'(1);
         end
         if (w_push) begin
            r_rspPc <= r_rspPc + 32'd4;
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // FIFO storage. It needs no reset because the count and pointers decide
   // which entries are live.
   always_ff @(posedge clk) begin
      if (w_push & ~reset) begin
         r_pcMem[r_wrPtr]    <= r_rspPc;
         r_instrMem[r_wrPtr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_rv32_ifetch.sv
// ---------------------------------------------------------------------------
// tb_rv32_ifetch
//
// Self-checking bench for rv32_ifetch. An in-order memory model with
// programmable latency answers every accepted request with
// data = addr ^ 32'hA5A5_A5A5. The directed steps push the {pc, instr}
// stream they expect into a scoreboard queue. A monitor pops the queue on
// every decode handshake and compares the popped entry with what the stage
// presents.
// ---------------------------------------------------------------------------
module tb_rv32_ifetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] XORK     = 32'hA5A5_A5A5;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   entry_t      expQ[$];
   logic [31:0] memAddrQ[$];
   int          memDueQ[$];
   int          popCyc[$];
   int          cyc      = 0;
   int          memLat   = 1;
   bit          randReq  = 1'b0;
   bit          randIf   = 1'b0;
   int          accSince = 0;
   int          popSince = 0;
   int          nCmp     = 0;
   int          nFail    = 0;

   rv32_ifetch #(
      .RESET_PC(RESET_PC),
      .DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_pc         (if_pc),
      .if_instr      (if_instr)
   );

   // Free-running clock and a cycle index that advances on every rising
   // edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      nCmp++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge. Inputs are driven here.
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   // Queue the n sequential entries expected from decode, starting at pc.
   task automatic pushExpect(input logic [31:0] start, input int n);
      logic [31:0] pc;
      pc = start;
      for (int i = 0; i < n; i++) begin
         expQ.push_back({pc, pc ^ XORK});
         pc = pc + 32'd4;
      end
   endtask

   // Hold a redirect for one cycle. In that cycle the stage must present
   // nothing to decode and request nothing from memory.
   task automatic applyStimulus(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      expQ.delete();
      accSince = 0;
      popSince = 0;
      @(negedge clk);
      checkOutput("redirIfValid", 32'(if_valid), 32'd0);
      checkOutput("redirReqValid", 32'(imem_req_valid), 32'd0);
      nextCycle();
      redirect_valid = 1'b0;
   endtask

   // Let decode accept entries until the scoreboard is empty, then stall
   // decode again.
   task automatic drain(input int budget);
      int k;
      k = 0;
      while (expQ.size() != 0 && k < budget) begin
         if (randIf) if_ready = 1'($urandom_range(0, 1));
         nextCycle();
         k++;
      end
      if_ready = 1'b0;
      checkOutput("drainLeft", 32'(expQ.size()), 32'd0);
   endtask

   // Memory model. Requests are answered in order, memLat cycles after they
   // are accepted, one response per cycle at most.
   initial begin
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_req_ready = randReq ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!reset && memAddrQ.size() > 0 && memDueQ[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memAddrQ[0] ^ XORK;
            void'(memAddrQ.pop_front());
            void'(memDueQ.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Monitor. It records accepted requests for the memory model, bounds the
   // credits in use, and scores every decode handshake.
   initial begin
      entry_t e;
      bit     pop;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pop = if_valid && if_ready;
            if (imem_req_valid && imem_req_ready) begin
               checkOutput("addrAlign", 32'(imem_req_addr[1:0]), 32'd0);
               memAddrQ.push_back(imem_req_addr);
               memDueQ.push_back(cyc + memLat);
               accSince++;
               checkOutput("creditBound",
                           32'((accSince - popSince - int'(pop)) <= DEPTH),
                           32'd1);
            end
            if (pop) begin
               popSince++;
               popCyc.push_back(cyc);
               checkOutput("popExpected", 32'(expQ.size() > 0), 32'd1);
               if (expQ.size() > 0) begin
                  e = expQ.pop_front();
                  checkOutput("ifPc", if_pc, e.pc);
                  checkOutput("ifInstr", if_instr, e.instr);
               end
            end
         end
      end
   end

   // Watchdog. It stops the run if a step loses its way.
   initial begin
      #300000;
      nFail++;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      int relCyc;
      int k;
      bit found;

      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if_ready       = 1'b0;

      // Outputs while reset is held.
      repeat (3) nextCycle();
      @(negedge clk);
      checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("rstIfValid", 32'(if_valid), 32'd0);
      checkOutput("rstAddr", imem_req_addr, RESET_PC);

      // Streaming from reset with a 1-cycle memory. The first request goes
      // out in the first cycle after reset. The first entry reaches decode
      // two cycles later, and entries then follow back to back.
      $display("[TB] streaming from reset");
      nextCycle();
      reset  = 1'b0;
      relCyc = cyc;
      popCyc.delete();
      pushExpect(RESET_PC, 12);
      if_ready = 1'b1;
      @(negedge clk);
      checkOutput("firstReqValid", 32'(imem_req_valid), 32'd1);
      checkOutput("firstReqAddr", imem_req_addr, RESET_PC);
      drain(60);
      checkOutput("popCount", 32'(popCyc.size()), 32'd12);
      if (popCyc.size() >= 12) begin
         checkOutput("firstPopLatency", 32'(popCyc[0] - relCyc), 32'd2);
         checkOutput("sustainedRate", 32'(popCyc[11] - popCyc[0]), 32'd11);
      end

      // Decode stall. Once the credits run out, fetch must stop. Releasing
      // decode must then resume the stream with nothing lost or duplicated.
      $display("[TB] decode stall");
      repeat (10) nextCycle();
      @(negedge clk);
      checkOutput("stallReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("stallIfValid", 32'(if_valid), 32'd1);
      nextCycle();
      pushExpect(32'h0000_0030, 8);
      if_ready = 1'b1;
      drain(60);

      // Redirect with two requests in flight on a 3-cycle memory.
      $display("[TB] redirect with two outstanding");
      memLat = 3;
      nextCycle();
      applyStimulus(32'h0000_0200);
      pushExpect(32'h0000_0200, 40);
      if_ready = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < 60) begin
         nextCycle();
         k++;
         found = (popSince >= 2) && (memAddrQ.size() == 2) && !imem_rsp_valid;
      end
      checkOutput("redir2Found", 32'(found), 32'd1);
      applyStimulus(32'h0000_0103);
      pushExpect(32'h0000_0100, 6);
      drain(100);

      // Redirect in the same cycle as a response, with decode ready and an
      // entry available. The response is dropped and nothing is popped.
      $display("[TB] redirect coincident with response");
      nextCycle();
      applyStimulus(32'h0000_0400);
      pushExpect(32'h0000_0400, 40);
      if_ready = 1'b1;
      found = 1'b0;
      k = 0;
      while (!found && k < 60) begin
         nextCycle();
         k++;
         found = (popSince >= 2) && imem_rsp_valid && if_valid;
      end
      checkOutput("redirRspFound", 32'(found), 32'd1);
      applyStimulus(32'h0000_0600);
      pushExpect(32'h0000_0600, 6);
      drain(100);

      // PC wrap from the top of the address space.
      $display("[TB] pc wrap");
      memLat = 1;
      nextCycle();
      applyStimulus(32'hFFFF_FFF8);
      pushExpect(32'hFFFF_FFF8, 4);
      if_ready = 1'b1;
      drain(60);

      // Random memory-ready and decode-ready on a 2-cycle memory.
      $display("[TB] random handshakes");
      memLat  = 2;
      randReq = 1'b1;
      randIf  = 1'b1;
      nextCycle();
      applyStimulus(32'h0000_1000);
      pushExpect(32'h0000_1000, 20);
      drain(400);
      randReq = 1'b0;
      randIf  = 1'b0;
      memLat  = 1;

      // Reset mid-burst with the FIFO full and an entry on offer to decode.
      $display("[TB] reset mid-burst");
      nextCycle();
      applyStimulus(32'h0000_2000);
      found = 1'b0;
      k = 0;
      while (!found && k < 30) begin
         nextCycle();
         k++;
         found = !imem_req_valid && if_valid && (memAddrQ.size() == 0);
      end
      checkOutput("fullFound", 32'(found), 32'd1);
      reset = 1'b1;
      memAddrQ.delete();
      memDueQ.delete();
      expQ.delete();
      accSince = 0;
      popSince = 0;
      @(negedge clk);
      checkOutput("midRstIfValid", 32'(if_valid), 32'd0);
      checkOutput("midRstReqValid", 32'(imem_req_valid), 32'd0);
      checkOutput("midRstAddr", imem_req_addr, RESET_PC);
      nextCycle();
      reset = 1'b0;
      pushExpect(RESET_PC, 4);
      if_ready = 1'b1;
      @(negedge clk);
      checkOutput("postRstIfValid", 32'(if_valid), 32'd0);
      checkOutput("postRstReqValid", 32'(imem_req_valid), 32'd1);
      checkOutput("postRstAddr", imem_req_addr, RESET_PC);
      drain(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
